// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync request path.
// Head classes and target-set helper used by the 1D controller.
package fractal_sync_pkg;

   localparam int N_PORTS = 2;

   typedef enum logic [1:0] {
      HEAD_MISS,
      HEAD_HIT,
      HEAD_PAIR,
      HEAD_ERR
   } fractal_sync_head_e;

   // Response registers a head needs before it may be consumed.
   function automatic logic [N_PORTS-1:0] head_targets(
      input fractal_sync_head_e kind,
      input int                 port
   );
      logic [N_PORTS-1:0] one;
      one = {{(N_PORTS-1){1'b0}}, 1'b1};
      unique case (kind)
         HEAD_ERR:            return one << port;
         HEAD_HIT, HEAD_PAIR: return '1;
         default:             return '0;
      endcase
   endfunction

endpackage

// File: rtl/fractal_sync_1d_req_ctrl_if.sv
// Child request/response and remote RF signals of a 1D node.
// The slave modport is the controller's view.
interface fractal_sync_1d_req_ctrl_if
   import fractal_sync_pkg::*;
#(
   parameter int unsigned LEVEL_WIDTH = 1,
   parameter int unsigned ID_WIDTH    = 1
);

   logic [N_PORTS-1:0]     req_valid_i;
   logic [N_PORTS-1:0]     req_ready_o;
   logic [LEVEL_WIDTH-1:0] req_level_i [N_PORTS];
   logic [ID_WIDTH-1:0]    req_id_i    [N_PORTS];

   logic [N_PORTS-1:0]     rsp_valid_o;
   logic [N_PORTS-1:0]     rsp_ready_i;
   logic [ID_WIDTH-1:0]    rsp_id_o    [N_PORTS];
   logic [N_PORTS-1:0]     rsp_err_o;

   logic [LEVEL_WIDTH-1:0] rf_level_o  [N_PORTS];
   logic [ID_WIDTH-1:0]    rf_id_o     [N_PORTS];
   logic [N_PORTS-1:0]     rf_check_o;
   logic [N_PORTS-1:0]     rf_present_i;
   logic [N_PORTS-1:0]     rf_sig_err_i;
   logic                   rf_bypass_i;

   modport slave (
      input  req_valid_i, req_level_i, req_id_i,
      output req_ready_o,
      output rsp_valid_o, rsp_id_o, rsp_err_o,
      input  rsp_ready_i,
      output rf_level_o, rf_id_o, rf_check_o,
      input  rf_present_i, rf_sig_err_i, rf_bypass_i
   );

   modport master (
      output req_valid_i, req_level_i, req_id_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_id_o, rsp_err_o,
      output rsp_ready_i,
      input  rf_level_o, rf_id_o, rf_check_o,
      output rf_present_i, rf_sig_err_i, rf_bypass_i
   );

endinterface

// File: rtl/fractal_sync_fifo.sv
// Generic non-fallthrough FIFO with registered full/empty.
// Push while full is honoured only when a pop happens in the same cycle.
module fractal_sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   T                mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q,  cnt_d;
   logic            do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/fractal_sync_1d_req_ctrl.sv
// Buffers child sync requests, presents heads to the remote RF and
// returns wake/error responses for synchronizations local to this node.
module fractal_sync_1d_req_ctrl
   import fractal_sync_pkg::*;
#(
   parameter int unsigned LEVEL_WIDTH = 1,
   parameter int unsigned ID_WIDTH    = 1,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   fractal_sync_1d_req_ctrl_if.slave  bus
);

   typedef struct packed {
      logic [LEVEL_WIDTH-1:0] level;
      logic [ID_WIDTH-1:0]    id;
   } fractal_sync_req_t;

   fractal_sync_req_t  push_data [N_PORTS];
   fractal_sync_req_t  head      [N_PORTS];
   logic [N_PORTS-1:0] push, full, empty, hv;

   fractal_sync_head_e kind [N_PORTS];
   logic [N_PORTS-1:0] tgt  [N_PORTS];
   logic [N_PORTS-1:0] rsp_free, ok, consume;
   logic               pair, conflict;

   logic               prio_q, prio_d;
   logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
   logic [N_PORTS-1:0] rsp_err_q,   rsp_err_d;
   logic [ID_WIDTH-1:0] rsp_id_q [N_PORTS];
   logic [ID_WIDTH-1:0] rsp_id_d [N_PORTS];

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      assign push_data[p] = '{level: bus.req_level_i[p],
                              id:    bus.req_id_i[p]};

      assign bus.req_ready_o[p] = ~full[p] & ~rst_i;
      assign push[p] = bus.req_valid_i[p] & bus.req_ready_o[p];
      assign hv[p]   = ~empty[p];

      fractal_sync_fifo #(
         .DEPTH (FIFO_DEPTH),
         .T     (fractal_sync_req_t)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[p]),
         .data_i  (push_data[p]),
         .pop_i   (consume[p]),
         .data_o  (head[p]),
         .full_o  (full[p]),
         .empty_o (empty[p])
      );

      assign bus.rf_level_o[p] = hv[p] ? head[p].level : '0;
      assign bus.rf_id_o[p]    = hv[p] ? head[p].id    : '0;
      assign bus.rsp_id_o[p]   = rsp_id_q[p];
   end

   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_err_o   = rsp_err_q;

   assign pair = hv[0] & hv[1] & bus.rf_bypass_i
               & ~bus.rf_sig_err_i[0] & ~bus.rf_sig_err_i[1];

   assign rsp_free = ~rsp_valid_q | bus.rsp_ready_i;

   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (!hv[p])                    kind[p] = HEAD_MISS;
         else if (bus.rf_sig_err_i[p])  kind[p] = HEAD_ERR;
         else if (pair)                 kind[p] = HEAD_PAIR;
         else if (bus.rf_present_i[p])  kind[p] = HEAD_HIT;
         else                           kind[p] = HEAD_MISS;
         tgt[p] = hv[p] ? head_targets(kind[p], p) : '0;
         ok[p]  = hv[p] & ((tgt[p] & ~rsp_free) == '0);
      end
   end

   // A PAIR shares its target set by construction and is never a conflict.
   assign conflict = ok[0] & ok[1] & (|(tgt[0] & tgt[1]))
                   & (kind[0] != HEAD_PAIR);

   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         consume[p] = ok[p] & ~(conflict & (prio_q != p[0]));
         bus.rf_check_o[p] = consume[p] & (kind[p] != HEAD_ERR);
      end
   end

   assign prio_d = prio_q ^ conflict;

   // Own ERR/HIT/PAIR head loads its register; a partner HIT also wakes it.
   always_comb begin
      for (int q = 0; q < N_PORTS; q++) begin
         rsp_valid_d[q] = rsp_valid_q[q] & ~bus.rsp_ready_i[q];
         rsp_err_d[q]   = rsp_err_q[q];
         rsp_id_d[q]    = rsp_id_q[q];
         if (consume[q] && kind[q] != HEAD_MISS) begin
            rsp_valid_d[q] = 1'b1;
            rsp_err_d[q]   = (kind[q] == HEAD_ERR);
            rsp_id_d[q]    = head[q].id;
         end else if (consume[q^1] && kind[q^1] == HEAD_HIT) begin
            rsp_valid_d[q] = 1'b1;
            rsp_err_d[q]   = 1'b0;
            rsp_id_d[q]    = head[q^1].id;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q      <= 1'b0;
         rsp_valid_q <= '0;
         rsp_err_q   <= '0;
         for (int q = 0; q < N_PORTS; q++) rsp_id_q[q] <= '0;
      end else begin
         prio_q      <= prio_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         for (int q = 0; q < N_PORTS; q++) rsp_id_q[q] <= rsp_id_d[q];
      end
   end

endmodule

// File: tb/tb_fractal_sync_1d_req_ctrl.sv
// Directed bench for the 1D request controller; the RF is played by
// hand-set present/sig_err/bypass values at each step.
module tb_fractal_sync_1d_req_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   fractal_sync_1d_req_ctrl_if #(
      .LEVEL_WIDTH (1),
      .ID_WIDTH    (1)
   ) bus ();

   fractal_sync_1d_req_ctrl #(
      .LEVEL_WIDTH (1),
      .ID_WIDTH    (1),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] v,
                      input logic id0, input logic id1);
      bus.req_valid_i = v;
      bus.req_id_i[0] = id0;
      bus.req_id_i[1] = id1;
   endtask

   initial begin
      bus.req_valid_i    = '0;
      bus.req_level_i[0] = 1'b0;
      bus.req_level_i[1] = 1'b0;
      bus.req_id_i[0]    = 1'b0;
      bus.req_id_i[1]    = 1'b0;
      bus.rsp_ready_i    = 2'b11;
      bus.rf_present_i   = '0;
      bus.rf_sig_err_i   = '0;
      bus.rf_bypass_i    = 1'b0;
      #2;
      chk("rst_rsp_valid", bus.rsp_valid_o, 2'b00);
      chk("rst_check",     bus.rf_check_o,  2'b00);
      chk("rst_ready",     bus.req_ready_o, 2'b00);
      chk("rst_rf_id0",    bus.rf_id_o[0],  0);
      tick();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", bus.req_ready_o, 2'b11);

      // MISS on port 0
      tick();
      req(2'b01, 1'b0, 1'b0);
      tick();
      req(2'b00, 1'b0, 1'b0);
      #1;
      chk("miss_check", bus.rf_check_o, 2'b01);
      tick();
      chk("miss_no_rsp", bus.rsp_valid_o, 2'b00);
      chk("miss_check_lo", bus.rf_check_o, 2'b00);

      // HIT on port 1 wakes both
      req(2'b10, 1'b0, 1'b0);
      tick();
      req(2'b00, 1'b0, 1'b0);
      bus.rf_present_i = 2'b10;
      #1;
      chk("hit_check", bus.rf_check_o, 2'b10);
      tick();
      bus.rf_present_i = 2'b00;
      #1;
      chk("hit_rsp_valid", bus.rsp_valid_o, 2'b11);
      chk("hit_rsp_id0", bus.rsp_id_o[0], 0);
      chk("hit_rsp_err", bus.rsp_err_o, 2'b00);
      tick();
      chk("hit_drained", bus.rsp_valid_o, 2'b00);

      // PAIR: both heads id=1 with bypass
      req(2'b11, 1'b1, 1'b1);
      tick();
      req(2'b00, 1'b1, 1'b1);
      bus.rf_bypass_i = 1'b1;
      #1;
      chk("pair_check", bus.rf_check_o, 2'b11);
      chk("pair_rf_id1", bus.rf_id_o[1], 1);
      tick();
      bus.rf_bypass_i = 1'b0;
      #1;
      chk("pair_rsp_valid", bus.rsp_valid_o, 2'b11);
      chk("pair_rsp_id0", bus.rsp_id_o[0], 1);
      chk("pair_rsp_id1", bus.rsp_id_o[1], 1);
      chk("pair_rsp_err", bus.rsp_err_o, 2'b00);
      tick();
      chk("pair_drained", bus.rsp_valid_o, 2'b00);

      // ERR on port 1
      req(2'b10, 1'b0, 1'b1);
      tick();
      req(2'b00, 1'b0, 1'b1);
      bus.rf_sig_err_i = 2'b10;
      #1;
      chk("err_check", bus.rf_check_o, 2'b00);
      chk("err_rf_id1", bus.rf_id_o[1], 1);
      tick();
      bus.rf_sig_err_i = 2'b00;
      #1;
      chk("err_rsp_valid", bus.rsp_valid_o, 2'b10);
      chk("err_rsp_err", bus.rsp_err_o[1], 1);
      chk("err_rsp_id1", bus.rsp_id_o[1], 1);
      tick();
      chk("err_drained", bus.rsp_valid_o, 2'b00);

      // HIT/HIT conflict, pointer at 0
      req(2'b11, 1'b0, 1'b1);
      tick();
      req(2'b00, 1'b0, 1'b1);
      bus.rf_present_i = 2'b11;
      #1;
      chk("c1_check_a", bus.rf_check_o, 2'b01);
      tick();
      chk("c1_rsp_valid_a", bus.rsp_valid_o, 2'b11);
      chk("c1_rsp_id1_a", bus.rsp_id_o[1], 0);
      chk("c1_check_b", bus.rf_check_o, 2'b10);
      tick();
      bus.rf_present_i = 2'b00;
      #1;
      chk("c1_rsp_id0_b", bus.rsp_id_o[0], 1);
      chk("c1_rsp_id1_b", bus.rsp_id_o[1], 1);
      tick();
      chk("c1_drained", bus.rsp_valid_o, 2'b00);

      // second conflict, pointer toggled to 1
      req(2'b11, 1'b1, 1'b0);
      tick();
      req(2'b00, 1'b1, 1'b0);
      bus.rf_present_i = 2'b11;
      #1;
      chk("c2_check_a", bus.rf_check_o, 2'b10);
      tick();
      chk("c2_rsp_id0_a", bus.rsp_id_o[0], 0);
      chk("c2_check_b", bus.rf_check_o, 2'b01);
      tick();
      bus.rf_present_i = 2'b00;
      #1;
      chk("c2_rsp_id0_b", bus.rsp_id_o[0], 1);
      tick();
      chk("c2_drained", bus.rsp_valid_o, 2'b00);

      // back-pressure on response 0
      bus.rsp_ready_i = 2'b10;
      req(2'b01, 1'b1, 1'b0);
      tick();
      req(2'b00, 1'b1, 1'b0);
      bus.rf_sig_err_i = 2'b01;
      #1;
      chk("bp_err_check", bus.rf_check_o, 2'b00);
      tick();
      bus.rf_sig_err_i = 2'b00;
      #1;
      chk("bp_err_valid", bus.rsp_valid_o, 2'b01);
      chk("bp_err_err", bus.rsp_err_o[0], 1);
      req(2'b01, 1'b0, 1'b0);
      bus.rf_present_i = 2'b01;
      tick();
      chk("bp_stall_a", bus.rf_check_o, 2'b00);
      chk("bp_ready_a", bus.req_ready_o, 2'b11);
      tick();
      chk("bp_full", bus.req_ready_o, 2'b10);
      chk("bp_stall_b", bus.rf_check_o, 2'b00);
      req(2'b10, 1'b0, 1'b1);
      tick();
      req(2'b00, 1'b0, 1'b1);
      #1;
      chk("bp_miss1", bus.rf_check_o, 2'b10);
      chk("bp_hold", bus.rsp_valid_o, 2'b01);
      tick();
      bus.rsp_ready_i = 2'b11;
      #1;
      chk("bp_release", bus.rf_check_o, 2'b01);
      tick();
      chk("bp_rsp_a_valid", bus.rsp_valid_o, 2'b11);
      chk("bp_rsp_a_err", bus.rsp_err_o, 2'b00);
      chk("bp_rsp_a_id0", bus.rsp_id_o[0], 0);
      chk("bp_ready_back", bus.req_ready_o, 2'b11);
      chk("bp_check_b", bus.rf_check_o, 2'b01);
      tick();
      chk("bp_rsp_b_valid", bus.rsp_valid_o, 2'b11);
      bus.rf_present_i = 2'b00;
      bus.rsp_ready_i  = 2'b00;
      req(2'b11, 1'b1, 1'b1);
      #1;
      chk("bp_empty_check", bus.rf_check_o, 2'b00);

      // reset mid-stream
      tick();
      req(2'b00, 1'b1, 1'b1);
      #1;
      chk("pre_rst_valid", bus.rsp_valid_o, 2'b11);
      chk("pre_rst_check", bus.rf_check_o, 2'b11);
      chk("pre_rst_rf_id0", bus.rf_id_o[0], 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.rsp_valid_o, 2'b00);
      chk("mid_rst_check", bus.rf_check_o, 2'b00);
      chk("mid_rst_ready", bus.req_ready_o, 2'b00);
      chk("mid_rst_rf_id0", bus.rf_id_o[0], 0);
      tick();
      rst = 1'b0;
      bus.rsp_ready_i = 2'b11;
      tick();
      chk("post_rst_ready", bus.req_ready_o, 2'b11);
      chk("post_rst_valid", bus.rsp_valid_o, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
